uart_sample_tx: RTL

Parametrised UART transmitter for streaming tactile ADC samples to a host. It buffers SAMPLE_WIDTH-bit samples in an internal FIFO and serialises each sample as ceil(SAMPLE_WIDTH/8) UART byte frames, most-significant byte first. Byte frames carry optional parity and a configurable stop-bit count. It replaces the fixed 12-bit, unbuffered transmitter, sitting between the sample arbiter and the board UART TX pin.

---
 rtl/uart_sample_tx.sv | 200 ++++++++++++++++++++
 1 files changed

// File: rtl/uart_sample_tx.sv
// Buffered UART transmitter for tactile ADC samples: a FIFO of SAMPLE_WIDTH-bit
// samples, each sent as ceil(SAMPLE_WIDTH/8) byte frames, most-significant byte first.
module uart_sample_tx #(
   parameter int SAMPLE_WIDTH = 12,
   parameter int BAUD_DIV     = 868,
   parameter int FIFO_DEPTH   = 8,
   parameter int PARITY_EN    = 0,
   parameter int PARITY_ODD   = 0,
   parameter int STOP_BITS    = 1
) (
   input  logic                              clk_in,
   input  logic                              rst_in,
   input  logic [SAMPLE_WIDTH-1:0]           data_in,
   input  logic                              data_valid_in,
   input  logic                              transmit_active,
   output logic                              ready_out,
   output logic                              busy_out,
   output logic                              overflow_out,
   output logic [$clog2(FIFO_DEPTH+1)-1:0]   fifo_count_out,
   output logic                              data_out
);

   localparam int NB        = (SAMPLE_WIDTH + 7) / 8;
   localparam int WW        = 8 * NB;
   localparam int CW        = $clog2(FIFO_DEPTH + 1);
   localparam int AW        = $clog2(FIFO_DEPTH);
   localparam int BW        = $clog2(BAUD_DIV);
   localparam int IW        = (NB > 1) ? $clog2(NB) : 1;
   localparam logic PODD    = (PARITY_ODD != 0);
   localparam logic [2:0] STOP_LAST = 3'(STOP_BITS - 1);

   typedef enum logic [2:0] {
      IDLE,
      START,
      DATA,
      PARITY,
      STOP
   } state_t;

   // ------------------------------------------------------------------
   // Sample FIFO
   // Handshake: a sample is taken on every rising edge where data_valid_in
   // and ready_out are both 1; ready_out reflects occupancy before any
   // same-cycle pop, so a write offered while full is dropped and flagged.
   // ------------------------------------------------------------------
   logic [SAMPLE_WIDTH-1:0] mem [FIFO_DEPTH];
   logic [AW-1:0]           wr_ptr;
   logic [AW-1:0]           rd_ptr;
   logic                    full;
   logic                    empty;
   logic                    push;
   logic                    pop;
   state_t                  state;

   assign full      = (fifo_count_out == CW'(FIFO_DEPTH));
   assign empty     = (fifo_count_out == '0);
   assign ready_out = !full;
   assign push      = data_valid_in && !full;
   assign pop       = (state == IDLE) && !empty && transmit_active;

   always_ff @(posedge clk_in) begin
      if (push) begin
         mem[wr_ptr] <= data_in;
      end
   end

   always_ff @(posedge clk_in or posedge rst_in) begin
      if (rst_in) begin
         wr_ptr         <= '0;
         rd_ptr         <= '0;
         fifo_count_out <= '0;
         overflow_out   <= 1'b0;
      end else begin
         overflow_out <= data_valid_in && full;
         if (push) begin
            wr_ptr <= wr_ptr + AW'(1);
         end
         if (pop) begin
            rd_ptr <= rd_ptr + AW'(1);
         end
         case ({push, pop})
            2'b10:   fifo_count_out <= fifo_count_out + CW'(1);
            2'b01:   fifo_count_out <= fifo_count_out - CW'(1);
            default: fifo_count_out <= fifo_count_out;
         endcase
      end
   end

   // ------------------------------------------------------------------
   // Serialiser
   // ------------------------------------------------------------------
   logic [WW-1:0] head_ext;
   logic [WW-1:0] word_q;
   logic [7:0]    tx_byte;
   logic [BW-1:0] baud_cnt;
   logic [2:0]    bit_cnt;
   logic [IW-1:0] byte_idx;
   logic          parity_q;
   logic          baud_end;
   logic          last_byte;

   assign head_ext  = WW'(mem[rd_ptr]);
   assign baud_end  = (baud_cnt == BW'(BAUD_DIV - 1));
   assign last_byte = (byte_idx == IW'(NB - 1));

   // data_out is always loaded with the value of the state being entered,
   // so the line changes exactly on the edge that changes the state.
   always_ff @(posedge clk_in or posedge rst_in) begin
      if (rst_in) begin
         state    <= IDLE;
         baud_cnt <= '0;
         bit_cnt  <= '0;
         byte_idx <= '0;
         tx_byte  <= '0;
         word_q   <= '0;
         parity_q <= 1'b0;
         data_out <= 1'b1;
         busy_out <= 1'b0;
      end else begin
         if (state != IDLE) begin
            baud_cnt <= baud_end ? '0 : baud_cnt + BW'(1);
         end
         case (state)
            IDLE: begin
               data_out <= 1'b1;
               if (pop) begin
                  state    <= START;
                  data_out <= 1'b0;
                  busy_out <= 1'b1;
                  baud_cnt <= '0;
                  byte_idx <= '0;
                  tx_byte  <= head_ext[WW-1 -: 8];
                  word_q   <= head_ext << 8;
               end
            end
            START: begin
               if (baud_end) begin
                  state    <= DATA;
                  bit_cnt  <= '0;
                  parity_q <= (^tx_byte) ^ PODD;
                  data_out <= tx_byte[0];
                  tx_byte  <= tx_byte >> 1;
               end
            end
            DATA: begin
               if (baud_end) begin
                  if (bit_cnt == 3'd7) begin
                     bit_cnt <= '0;
                     if (PARITY_EN != 0) begin
                        state    <= PARITY;
                        data_out <= parity_q;
                     end else begin
                        state    <= STOP;
                        data_out <= 1'b1;
                     end
                  end else begin
                     bit_cnt  <= bit_cnt + 3'd1;
                     data_out <= tx_byte[0];
                     tx_byte  <= tx_byte >> 1;
                  end
               end
            end
            PARITY: begin
               if (baud_end) begin
                  state    <= STOP;
                  bit_cnt  <= '0;
                  data_out <= 1'b1;
               end
            end
            STOP: begin
               if (baud_end) begin
                  if (bit_cnt == STOP_LAST) begin
                     bit_cnt <= '0;
                     if (!last_byte) begin
                        // next byte of the same sample follows with no gap
                        state    <= START;
                        data_out <= 1'b0;
                        byte_idx <= byte_idx + IW'(1);
                        tx_byte  <= word_q[WW-1 -: 8];
                        word_q   <= word_q << 8;
                     end else begin
                        state    <= IDLE;
                        busy_out <= 1'b0;
                        data_out <= 1'b1;
                     end
                  end else begin
                     bit_cnt <= bit_cnt + 3'd1;
                  end
               end
            end
            default: begin
               state    <= IDLE;
               data_out <= 1'b1;
               busy_out <= 1'b0;
            end
         endcase
      end
   end

endmodule
